// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite engine: register-field selects, sprite
// direction encoding and the per-sprite register record.
package sprite_pkg;
    localparam logic [1:0] FLD_X    = 2'b00;
    localparam logic [1:0] FLD_Y    = 2'b01;
    localparam logic [1:0] FLD_DIR  = 2'b10;
    localparam logic [1:0] FLD_CTRL = 2'b11;

    // Coordinates are held at this width, zero-extended from COORD_W.
    localparam int REG_COORD_W = 16;

    typedef enum logic [1:0] {UP, RIGHT, DOWN, LEFT} dir_e;

    typedef struct packed {
        logic [REG_COORD_W-1:0] x;
        logic [REG_COORD_W-1:0] y;
        dir_e                   dir;
        logic                   en;
    } sprite_regs_t;
endpackage

// File: rtl/sprite_hit.sv
// Per-sprite combinational hit test and ROM row/col generation.
// Rotation by direction is built only when SPRITE_ROTATE_EN is defined.
module sprite_hit
    import sprite_pkg::*;
#(
    parameter  int HALF_SIZE = 16,
    parameter  int COORD_W   = 10,
    localparam int S         = 2 * HALF_SIZE,
    localparam int SW        = $clog2(S)
) (
    input  sprite_regs_t         regs,
    input  logic [COORD_W-1:0]   px,
    input  logic [COORD_W-1:0]   py,
    output logic                 hit,
    output logic [SW-1:0]        row,
    output logic [SW-1:0]        col
);
    // Two guard bits keep x+H and px-(x-H) exact for any stored coordinate.
    localparam int CW = REG_COORD_W + 2;
    localparam logic signed [CW-1:0] H_C  = CW'(HALF_SIZE);
    localparam logic signed [CW-1:0] S_C  = CW'(S);
    localparam logic signed [CW-1:0] Z_C  = '0;
    localparam logic [SW-1:0]        MAXC = SW'(S - 1);

    logic signed [CW-1:0] dx, dy;
    logic [SW-1:0]        lx, ly;

    always_comb begin
        dx  = $signed(CW'(px)) - ($signed(CW'(regs.x)) - H_C);
        dy  = $signed(CW'(py)) - ($signed(CW'(regs.y)) - H_C);
        hit = regs.en && (dx >= Z_C) && (dx < S_C) && (dy >= Z_C) && (dy < S_C);
        lx  = dx[SW-1:0];
        ly  = dy[SW-1:0];
    end

`ifdef SPRITE_ROTATE_EN
    always_comb begin
        row = ly;
        col = lx;
        case (regs.dir)
            RIGHT:   begin row = MAXC - lx; col = ly;        end
            DOWN:    begin row = MAXC - ly; col = MAXC - lx; end
            LEFT:    begin row = lx;        col = MAXC - ly; end
            default: ;
        endcase
    end
`else
    logic unused_rot;
    assign unused_rot = ^{regs.dir, MAXC};
    assign row = ly;
    assign col = lx;
`endif
endmodule

// File: rtl/sprite_engine.sv
// Multi-sprite pixel source: staged/active sprite registers committed at frame
// start, lowest-index priority hit, 3-cycle pixel pipeline through sprite ROM.
// Optional SPRITE_ROTATE_EN enables per-sprite 90-degree rotation.
module sprite_engine
    import sprite_pkg::*;
#(
    parameter  int          NUM_SPRITES     = 4,
    parameter  int          HALF_SIZE       = 16,
    parameter  int          COORD_W         = 10,
    parameter  logic [23:0] TRANSPARENT_KEY = 24'hFF00FF,
    localparam int          IW              = $clog2(NUM_SPRITES),
    localparam int          S               = 2 * HALF_SIZE,
    localparam int          SW              = $clog2(S),
    localparam int          AW              = IW + 2 * SW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MW_i,
    input  logic [IW+1:0]   address_i,
    input  logic [31:0]     data_i,
    input  logic            frame_start_i,
    input  logic [31:0]     x_pos_i,
    input  logic [31:0]     y_pos_i,
    output logic [AW-1:0]   mem_address_o,
    input  logic [23:0]     mem_data_i,
    output logic [23:0]     RGB_o,
    output logic            hit_o
);
    localparam int IDX_W = (IW > 0) ? IW : 1;

    function automatic sprite_regs_t reset_regs(int i);
        sprite_regs_t r;
        r.x   = REG_COORD_W'(60 + 30 * i);
        r.y   = REG_COORD_W'(40 + 30 * i);
        r.dir = UP;
        r.en  = 1'b1;
        return r;
    endfunction

    sprite_regs_t     stg [NUM_SPRITES];
    sprite_regs_t     act [NUM_SPRITES];
    logic [IDX_W-1:0] wr_idx;

    assign wr_idx = IDX_W'(address_i >> 2);

    // act copies the pre-write staging value when a write meets frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                stg[i] <= reset_regs(i);
                act[i] <= reset_regs(i);
            end
        end else begin
            if (frame_start_i)
                for (int i = 0; i < NUM_SPRITES; i++) act[i] <= stg[i];
            if (MW_i) begin
                case (address_i[1:0])
                    FLD_X:   stg[wr_idx].x   <= REG_COORD_W'(data_i[COORD_W-1:0]);
                    FLD_Y:   stg[wr_idx].y   <= REG_COORD_W'(data_i[COORD_W-1:0]);
                    FLD_DIR: stg[wr_idx].dir <= dir_e'(data_i[1:0]);
                    default: stg[wr_idx].en  <= data_i[0];
                endcase
            end
        end
    end

    logic [NUM_SPRITES-1:0]         hits;
    logic [NUM_SPRITES-1:0][SW-1:0] rows;
    logic [NUM_SPRITES-1:0][SW-1:0] cols;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
        sprite_hit #(
            .HALF_SIZE (HALF_SIZE),
            .COORD_W   (COORD_W)
        ) u_hit (
            .regs (act[g]),
            .px   (x_pos_i[COORD_W-1:0]),
            .py   (y_pos_i[COORD_W-1:0]),
            .hit  (hits[g]),
            .row  (rows[g]),
            .col  (cols[g])
        );
    end

    logic [IDX_W-1:0] sel;
    logic             any_hit;
    logic [AW-1:0]    addr_next;

    always_comb begin
        sel = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--)
            if (hits[i]) sel = IDX_W'(i);
        any_hit   = |hits;
        addr_next = any_hit ? AW'({sel, rows[sel], cols[sel]}) : '0;
    end

    // vld_pipe[1]: hit for the address on mem_address_o; vld_pipe[2]: hit
    // aligned with mem_data_i.
    logic [2:1] vld_pipe;
    logic       opaque;

    assign opaque = vld_pipe[2] && (mem_data_i != TRANSPARENT_KEY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_address_o <= '0;
            vld_pipe      <= '0;
            RGB_o         <= '0;
            hit_o         <= 1'b0;
        end else begin
            mem_address_o <= addr_next;
            vld_pipe      <= {vld_pipe[1], any_hit};
            hit_o         <= opaque;
            RGB_o         <= opaque ? mem_data_i : '0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{data_i[31:COORD_W], x_pos_i[31:COORD_W], y_pos_i[31:COORD_W]};
endmodule

// File: tb/tb_sprite_engine.sv
// Bench for sprite_engine: integer-arithmetic sprite model checked every cycle,
// plus directed scans with hand-computed addresses and colours.
module tb_sprite_engine;
    localparam int          N   = 4;
    localparam int          H   = 16;
    localparam int          S   = 32;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        MW_i;
    logic [3:0]  address_i;
    logic [31:0] data_i;
    logic        frame_start_i;
    logic [31:0] x_pos_i, y_pos_i;
    logic [11:0] mem_address_o;
    logic [23:0] mem_data_i;
    logic [23:0] RGB_o;
    logic        hit_o;

    always #5 clk = ~clk;

    sprite_engine dut (
        .clk           (clk),
        .rst           (rst),
        .MW_i          (MW_i),
        .address_i     (address_i),
        .data_i        (data_i),
        .frame_start_i (frame_start_i),
        .x_pos_i       (x_pos_i),
        .y_pos_i       (y_pos_i),
        .mem_address_o (mem_address_o),
        .mem_data_i    (mem_data_i),
        .RGB_o         (RGB_o),
        .hit_o         (hit_o)
    );

    int rom_mode = 0;

    function automatic logic [23:0] rom_fn(int mode, logic [11:0] a);
        case (mode)
            0:       return 24'h123456;
            1:       return KEY;
            default: return {12'hA50, a};
        endcase
    endfunction

    // Synchronous sprite ROM
    always @(posedge clk) mem_data_i <= rom_fn(rom_mode, mem_address_o);

    int tests = 0, fails = 0;
    bit chk_en = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- model ----------------
    int sx[N], sy[N], sd[N], se[N];
    int ax[N], ay[N], ad[N], ae[N];

    typedef struct packed {
        logic        hit;
        logic [11:0] addr;
        logic [23:0] rom;
    } ent_t;

    ent_t        p1, p2;
    logic        e_hit;
    logic [23:0] e_rgb;

    function automatic ent_t eval(int px, int py);
        ent_t e = '0;
        for (int i = 0; i < N; i++) begin
            if (ae[i] != 0 && px >= ax[i] - H && px < ax[i] + H &&
                py >= ay[i] - H && py < ay[i] + H) begin
                int lx = px - (ax[i] - H);
                int ly = py - (ay[i] - H);
                int r = ly, c = lx;
`ifdef SPRITE_ROTATE_EN
                case (ad[i])
                    1:       begin r = S - 1 - lx; c = ly;         end
                    2:       begin r = S - 1 - ly; c = S - 1 - lx; end
                    3:       begin r = lx;         c = S - 1 - ly; end
                    default: ;
                endcase
`endif
                e.hit  = 1'b1;
                e.addr = 12'(i * S * S + r * S + c);
                return e;
            end
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                sx[i] <= 60 + 30 * i; sy[i] <= 40 + 30 * i; sd[i] <= 0; se[i] <= 1;
                ax[i] <= 60 + 30 * i; ay[i] <= 40 + 30 * i; ad[i] <= 0; ae[i] <= 1;
            end
            p1 <= '0; p2 <= '0; e_hit <= 1'b0; e_rgb <= '0;
        end else begin
            p1    <= eval(int'(x_pos_i[9:0]), int'(y_pos_i[9:0]));
            p2    <= '{hit: p1.hit, addr: p1.addr, rom: rom_fn(rom_mode, p1.addr)};
            e_hit <= p2.hit && p2.rom != KEY;
            e_rgb <= (p2.hit && p2.rom != KEY) ? p2.rom : 24'h0;
            if (frame_start_i)
                for (int i = 0; i < N; i++) begin
                    ax[i] <= sx[i]; ay[i] <= sy[i]; ad[i] <= sd[i]; ae[i] <= se[i];
                end
            if (MW_i) begin
                case (address_i[1:0])
                    2'd0:    sx[address_i[3:2]] <= int'(data_i[9:0]);
                    2'd1:    sy[address_i[3:2]] <= int'(data_i[9:0]);
                    2'd2:    sd[address_i[3:2]] <= int'(data_i[1:0]);
                    default: se[address_i[3:2]] <= int'(data_i[0]);
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("model_addr", 32'(mem_address_o), 32'(p1.addr));
            check("model_hit", 32'(hit_o), 32'(e_hit));
            check("model_rgb", 32'(RGB_o), 32'(e_rgb));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(int idx, int fld, int val, bit fs = 1'b0);
        address_i     = 4'(idx * 4 + fld);
        data_i        = val;
        MW_i          = 1'b1;
        frame_start_i = fs;
        tick();
        MW_i          = 1'b0;
        frame_start_i = 1'b0;
    endtask

    task automatic commit();
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
    endtask

    task automatic scan(string nm, int px, int py, int ea, int eh, logic [23:0] ergb);
        x_pos_i = px;
        y_pos_i = py;
        tick();
        check({nm, "_addr"}, 32'(mem_address_o), ea);
        tick();
        tick();
        check({nm, "_hit"}, 32'(hit_o), eh);
        check({nm, "_rgb"}, 32'(RGB_o), 32'(ergb));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; MW_i = 1'b0; address_i = '0; data_i = '0; frame_start_i = 1'b0;
        x_pos_i = '0; y_pos_i = '0;
        repeat (2) tick();
        check("reset_addr", 32'(mem_address_o), 0);
        check("reset_hit", 32'(hit_o), 0);
        check("reset_rgb", 32'(RGB_o), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        scan("s0_center", 60, 40, 528, 1, 24'h123456);

        wr(1, 0, 200);
        scan("staged_hidden", 200, 70, 0, 0, 24'h0);
        commit();
        scan("s1_committed", 200, 70, 1552, 1, 24'h123456);

        wr(0, 0, 100); wr(0, 1, 100); wr(1, 0, 100); wr(1, 1, 100);
        commit();
        scan("prio_s0", 100, 100, 528, 1, 24'h123456);
        wr(0, 3, 0);
        commit();
        scan("prio_s1", 100, 100, 1552, 1, 24'h123456);

        wr(0, 3, 1); wr(0, 0, 5);
        commit();
        scan("clip_left", 0, 100, 523, 1, 24'h123456);
        scan("no_wrap", 1021, 100, 0, 0, 24'h0);

        wr(0, 0, 100); wr(0, 2, 1);
        commit();
`ifdef SPRITE_ROTATE_EN
        scan("dir1_corner", 84, 84, 992, 1, 24'h123456);
`else
        scan("dir1_corner", 84, 84, 0, 1, 24'h123456);
`endif

        rom_mode = 1;
        repeat (3) tick();
`ifdef SPRITE_ROTATE_EN
        scan("transparent", 100, 100, 496, 0, 24'h0);
`else
        scan("transparent", 100, 100, 528, 0, 24'h0);
`endif
        rom_mode = 2;
        repeat (3) tick();

        // Write in the same cycle as frame start lands next frame.
        wr(2, 0, 300, 1'b1);
        scan("same_cycle_wr", 300, 100, 0, 0, 24'h0);
        commit();
        scan("next_frame", 300, 100, 2576, 1, 24'hA50A10);

        // Back-to-back frame starts, each carrying a write.
        wr(3, 0, 310, 1'b1);
        wr(3, 1, 100, 1'b1);
        scan("b2b_fs", 310, 100, 2586, 1, 24'hA50A1A);

        wr(1, 2, 2); wr(3, 2, 3); wr(2, 2, 1);
        commit();
        for (int i = 0; i < 400; i++) begin
            x_pos_i = (i * 7) % 1024;
            y_pos_i = 70 + (i % 64);
            if (i == 150) wr(2, 0, 20, 1'b1);
            else if (i == 151) wr(0, 1, 90, 1'b1);
            else tick();
        end

        x_pos_i = 100; y_pos_i = 100;
        tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_addr", 32'(mem_address_o), 0);
        check("midrst_hit", 32'(hit_o), 0);
        check("midrst_rgb", 32'(RGB_o), 0);
        tick();
        rst = 1'b0;
        scan("after_reset", 60, 40, 528, 1, 24'hA50210);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
